// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and status bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_LSL = 3'b111;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  localparam int ZF = 0;
  localparam int VF = 1;
  localparam int NF = 2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per op.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mpr_q, mpr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [2*WIDTH-1:0] addend;

  // product already folds in the current iteration so the final value is usable on the done edge
  assign addend  = mpr_q[0] ? mcand_q : '0;
  assign product = acc_q + addend;
  assign done    = run_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mpr_d   = mpr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, a};
      mpr_d   = b;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      acc_d   = product;
      mcand_d = mcand_q << 1;
      mpr_d   = mpr_q >> 1;
      if (done) begin
        cnt_d = '0;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mpr_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mpr_q   <= mpr_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready operand capture; MUL stalls the front end for WIDTH cycles.
// Handshake: a transfer happens on a rising edge where in_valid & in_ready; in_ready depends on state only.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       Z,
  output logic             out_valid,
  output state_t           dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [2:0]         z_q, z_d;
  logic               out_valid_q, out_valid_d;

  logic               accept, is_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   sum, diff, shl, alu_res, load_res;
  logic               alu_v, load_v, load_en;

  assign in_ready    = (state_q == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign is_mul      = (ALUop == OP_MUL);
  assign mul_start   = accept && is_mul;
  assign dbg_state_o = state_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (Ain),
    .b       (Bin),
    .done    (mul_done),
    .product (mul_product)
  );

  assign sum  = Ain + Bin;
  assign diff = Ain - Bin;
  assign shl  = Ain << Bin[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (Ain[MSB] == Bin[MSB]) && (sum[MSB] != Ain[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (Ain[MSB] != Bin[MSB]) && (diff[MSB] != Ain[MSB]);
      end
      OP_AND:  alu_res = Ain & Bin;
      OP_NOT:  alu_res = ~Bin;
      OP_OR:   alu_res = Ain | Bin;
      OP_XOR:  alu_res = Ain ^ Bin;
      OP_LSL:  alu_res = shl;
      default: alu_res = '0;
    endcase
  end

  // accept (IDLE only) and mul_done (BUSY only) are mutually exclusive
  assign load_en  = (accept && !is_mul) || mul_done;
  assign load_res = mul_done ? mul_product[WIDTH-1:0] : alu_res;
  assign load_v   = mul_done ? (|mul_product[2*WIDTH-1:WIDTH]) : alu_v;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    z_d         = z_q;
    out_valid_d = 1'b0;
    if (load_en) begin
      out_d       = load_res;
      z_d[ZF]     = (load_res == '0);
      z_d[VF]     = load_v;
      z_d[NF]     = load_res[MSB];
      out_valid_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_BUSY;
      ST_BUSY: if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      z_q         <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign Z         = z_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the datapath; the next generation of the 16-bit combinational ALU. Adds a valid/ready operand handshake and three more single-cycle ops: OR, XOR, and a logical left shift. Adds a multi-cycle unsigned shift-add multiply. Results and N/V/Z status are registered. The block sits between the register-file read ports and the writeback/status register, and can stall the controller through `in_ready`.

## Interface
- `WIDTH`, 16, operand/result width (≥4, power of two).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `Ain`, `Bin`  in  WIDTH  operands.
- `ALUop`  in  3  operation select:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 NOT Bin
  - 100 OR
  - 101 XOR
  - 110 MUL
  - 111 LSL Ain by `Bin[$clog2(WIDTH)-1:0]`
- `out`  out  WIDTH  registered result.
- `Z`  out  3  registered status: `Z[0]` zero, `Z[1]` overflow V, `Z[2]` negative N.
- `out_valid`  out  1  one-cycle pulse when `out`/`Z` update.

## Operation
- Transfer occurs on a rising edge with `in_valid & in_ready`. `Ain`, `Bin` and `ALUop` are captured at that edge only.
- Changes on the inputs after capture are ignored.
- `in_valid` while busy is ignored: not queued, no error.
- States:
  - IDLE: `in_ready=1`. Accepting a non-MUL op stays in IDLE. Accepting MUL goes to BUSY.
  - BUSY: `in_ready=0`. Runs one shift-add iteration per cycle with iteration counter 0..WIDTH-1. On the final iteration, loads the result and returns to IDLE.
- Arithmetic: all results are truncated to WIDTH bits.
- V flag:
  - ADD: `Ain[MSB]==Bin[MSB]` and `sum[MSB]!=Ain[MSB]`.
  - SUB: `Ain[MSB]!=Bin[MSB]` and `diff[MSB]!=Ain[MSB]`.
  - MUL: unsigned; V=1 iff the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - All other ops: V=0.
- N = `result[MSB]`. Zero = (result==0). Both are computed from the result being loaded, never from stale `out`.
- LSL fills with zeros. A shift amount of 0 passes `Ain` through unchanged.
- `out` and `Z` hold their last value between results.
- Reset (`reset_n=0` at an edge), including mid-multiply:
  - state→IDLE, iteration counter→0.
  - `out`→0, `Z`→3'b000, `out_valid`→0.
  - No pending result is delivered.
- Reset has priority over a simultaneous transfer.

## Timing
- Let E0 be the accepting edge.
- Single-cycle ops: `out`, `Z` and `out_valid=1` are visible in the cycle after E0, so latency is 1. `in_ready` stays high, so back-to-back transfers on consecutive edges give one result per cycle.
- MUL:
  - `in_ready` is low for the WIDTH cycles following E0.
  - The result is loaded at edge E0+WIDTH.
  - `out_valid` pulses in the cycle after E0+WIDTH, coincident with `in_ready` returning high.
  - A new transfer can occur at edge E0+WIDTH+1.
- `out_valid` is never high for two consecutive cycles from the same transfer.
- `in_ready` is a function of state only; no combinational path from `in_valid`.

## Structure
- Package `alu_pkg`:
  - `ALUop` encodings as named constants.
  - State typedef (IDLE, BUSY).
  - Status bit indices (ZF=0, VF=1, NF=2).
- Sub-module `alu_mul_iter`, parameterised by WIDTH:
  - Holds the accumulator, multiplicand and multiplier shift registers and the iteration counter.
  - Interface: `start`, `done`, `product[2*WIDTH-1:0]`.
- The top level holds the FSM, the single-cycle datapath, the flag logic and the output registers.

## Test plan
- Reset: hold `reset_n=0` for 2 cycles → `out=0`, `Z=000`, `out_valid=0`, `in_ready=1`.
- ADD overflow, WIDTH=16: `0x7FFF`+`0x0001` → next cycle `out=0x8000`, `Z=110`, single `out_valid` pulse. Then back-to-back SUB `0x1234-0x1234` on the next edge → `out=0`, `Z=001` one cycle later.
- MUL, WIDTH=16: `300*300` → `in_ready` low for 16 cycles, `in_valid` pulses during BUSY ignored. Result `out=0x5F90`, `Z=010`, `out_valid` exactly 16 cycles after the accepting edge's following cycle boundary, i.e. in the cycle after E0+16.
- LSL/XOR/NOT: LSL `Ain=0x0001`, `Bin=0x000F` → `0x8000`, `Z=100`. XOR `0xAAAA^0xAAAA` → 0, `Z=001`. NOT `Bin=0xFFFF` → 0, `Z=001`.
- Reset mid-MUL: assert `reset_n=0` at iteration 5 → no `out_valid` ever for that op, `out=0`, `in_ready=1` after the reset edge. A fresh ADD `2+3` then gives `out=5`.
- WIDTH=8 instance: MUL `0x10*0x10` → `out=0x00`, `Z=011` after 8 cycles. LSL by `Bin=0x0B` uses only 3 bits (shift 3): `0x01`→`0x08`.
